// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat bundle carrying a control word and a data word between pipeline stages.
interface pipe_stage_skid_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 192
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush-to-bubble and a
// saturating count of flushes that actually killed a beat.
//
// state | meaning
// EMPTY | no beat held, output shows a bubble
// FULL  | main holds the beat on the output
// SKID  | main on the output, skid holds the next beat, upstream stalled
module pipe_stage_skid #(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 192,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    pipe_stage_skid_if.slave    up,
    pipe_stage_skid_if.master   dn,
    output logic [CNT_W-1:0]    flush_cnt
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t            state, state_nxt;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              in_ready, out_valid;
    logic              accept, emit, kill;
    logic              load_in, load_from_skid, load_skid;

    assign in_ready  = (state != SKID);
    assign out_valid = (state != EMPTY);
    assign accept    = up.valid & in_ready & ~flush;
    assign emit      = out_valid & dn.ready;
    assign kill      = out_valid | up.valid;

    assign up.ready = in_ready;
    assign dn.valid = out_valid;
    assign dn.ctrl  = out_valid ? main_ctrl : '0;
    assign dn.data  = main_data;

    always_comb begin
        state_nxt      = state;
        load_in        = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_in   = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (emit && accept) begin
                    load_in = 1'b1;
                end else if (emit) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = SKID;
                end
            end
            SKID: begin
                if (emit) begin
                    load_from_skid = 1'b1;
                    state_nxt      = FULL;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A flush wins over every load; an emit this cycle was already sampled downstream.
        if (flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                main_ctrl <= '0;
                skid_ctrl <= '0;
                if (CLEAR_DATA != 0) begin
                    main_data <= '0;
                    skid_data <= '0;
                end
                if (kill && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
            end else begin
                if (load_in) begin
                    main_ctrl <= up.ctrl;
                    main_data <= up.data;
                end else if (load_from_skid) begin
                    main_ctrl <= skid_ctrl;
                    main_data <= skid_data;
                end
                if (load_skid) begin
                    skid_ctrl <= up.ctrl;
                    skid_data <= up.data;
                end
            end
        end
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register for the miniLA pipeline.
- Generalises the fixed ID/EX latch to arbitrary control and data widths.
- Adds a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not form a combinational ready path across stages.
- Adds a synchronous flush that inserts a bubble, plus a saturating flush-event counter for debug/perf readout.

Parameters:
CTRL_W, 16, width of control bundle (npc_op, wD_sel, wb_ena, dram_sel, alu_op, ...); bubble value is all-zero.
DATA_W, 192, width of data bundle (inst, pc, pc4, rD1, rD2, ext values, ...).
CLEAR_DATA, 1, 1 = data field zeroed on flush/reset; 0 = data field keeps stale value (saves area).
CNT_W, 16, width of flush_cnt.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  kill all held and incoming beats this cycle
in_valid  in  1  upstream beat present
in_ready  out  1  stage can accept a beat
in_ctrl  in  CTRL_W  upstream control bundle
in_data  in  DATA_W  upstream data bundle
out_valid  out  1  beat present at output
out_ready  in  1  downstream accepts beat
out_ctrl  out  CTRL_W  output control bundle (0 when out_valid=0)
out_data  out  DATA_W  output data bundle
flush_cnt  out  CNT_W  saturating count of flush cycles that killed at least one beat

Behaviour:
- All state is on posedge clk. Reset is synchronous and active-high, with priority over everything else.
- Reset values: out_valid=0, out_ctrl=0, out_data=0, flush_cnt=0, skid entry invalid, state=EMPTY.
- Beats presented while rst=1 are ignored.
- Storage is a main register (drives outputs) and a skid register.
- in_ready = (state != SKID). It depends only on registered state, never on out_ready.
- Transfer definitions: accept = in_valid & in_ready & !flush; emit = out_valid & out_ready.
- States:
  - EMPTY: out_valid=0. On accept, load main and go to FULL.
  - FULL: out_valid=1.
    - emit & accept: load main with the new beat; stay FULL.
    - emit only: go to EMPTY.
    - accept only: load skid; go to SKID.
    - Neither: hold.
  - SKID: out_valid=1, in_ready=0. On emit, copy skid into main and go to FULL. Otherwise hold.
- Latency: a beat accepted in cycle N is visible at the outputs in cycle N+1 when the stage is empty. Throughput is 1 beat/cycle while out_ready=1.
- Ordering is strictly FIFO; no beat is duplicated or dropped except by flush.
- out_ctrl is forced to 0 whenever out_valid=0, so downstream sees a bubble (wb_ena=0, no memory op).
- Flush (rst=0, flush=1):
  - Next state is EMPTY; main and skid are invalidated.
  - out_ctrl is cleared to 0. out_data is cleared if CLEAR_DATA=1.
  - The incoming beat that cycle is discarded even if in_valid & in_ready.
  - An emit in the same cycle still counts as completed, because downstream sampled it.
- flush_cnt increments by 1 when flush=1 & rst=0 and at least one of {main valid, skid valid, in_valid} is true.
  - It saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous flush with out_ready=1 and a valid main entry: the output beat is considered taken and nothing is re-presented next cycle.
- Reset mid-operation: every held beat is lost and flush_cnt returns to 0. The stage is ready (in_ready=1) in the first cycle after rst falls.
- When out_ready is held high, the stage never enters SKID.

Test Plan:
- Reset then stream: assert rst for 2 cycles, then drive in_valid=1 with ctrl 0x0001..0x0004 and out_ready=1. Required: out_valid rises 1 cycle after the first accept, outputs 0x0001..0x0004 on consecutive cycles, in_ready stays 1.
- Back-pressure: hold out_ready=0 while sending ctrl 0x00A1 then 0x00A2.
  - After the second accept, in_ready=0 and out_ctrl=0x00A1.
  - Release out_ready: outputs 0x00A1 then 0x00A2; in_ready returns to 1 one cycle after the first emit.
- Flush in SKID with in_valid=1 carrying 0x00B3: in the next cycle out_valid=0, out_ctrl=0, and out_data=0 (CLEAR_DATA=1). 0x00B3 never appears and flush_cnt=1.
- Flush while empty and in_valid=0: flush_cnt is unchanged. Flush with in_valid=1 while empty: flush_cnt increments and the beat is dropped.
- Saturation with CNT_W=2: apply 5 killing flushes. Required: flush_cnt reads 1, 2, 3, 3, 3.
- Mid-stream reset with FULL state holding 0x00C7: assert rst for 1 cycle. Required: out_valid=0 and flush_cnt=0 next cycle, in_ready=1, and 0x00C7 never emitted.
